// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART bridge: FSM state encoding,
// overrun detection window and a small sizing helper.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StWrSetup    = 3'd1,
        StWrPulse    = 3'd2,
        StWrHold     = 3'd3,
        StWrWaitTbre = 3'd4,
        StWrWaitTsre = 3'd5,
        StRdPulse    = 3'd6,
        StRdRecover  = 3'd7
    } state_t;

    localparam int unsigned OVR_WINDOW = 256;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact occupancy count; a write while full is accepted
// only if a read happens in the same cycle (the read is taken first).
module sync_fifo
    import uart_bridge_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [W-1:0]             i_wr_data,
    input  logic                     i_rd_en,
    output logic [W-1:0]             o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW + 1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_pop     = i_rd_en && !o_empty;
    assign w_push    = i_wr_en && (!o_full || i_rd_en);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/uart_bridge.sv
// Stream-to-CPLD-UART bridge: TX/RX FIFOs plus a timed rdn/wrn strobe FSM on
// the shared RAM1 data bus, with RAM1 held deselected.
module uart_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned RECOVER_CYC = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_tbre,
    input  logic                        i_tsre,
    input  logic                        i_data_ready,
    inout  logic [DATA_W-1:0]           io_bus_data,
    output logic                        o_rdn,
    output logic                        o_wrn,
    output logic                        o_ram_oe,
    output logic                        o_ram_we,
    output logic                        o_ram_en,
    input  logic [DATA_W-1:0]           i_tx_data,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    output logic [DATA_W-1:0]           o_rx_data,
    output logic                        o_rx_valid,
    input  logic                        i_rx_ready,
    output logic [$clog2(TX_DEPTH):0]   o_tx_count,
    output logic [$clog2(RX_DEPTH):0]   o_rx_count,
    output logic [3:0]                  o_status
);

    localparam int unsigned CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, RECOVER_CYC) + 1);
    localparam int unsigned OVR_W = $clog2(OVR_WINDOW);

    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rdn;
    logic              r_wrn;
    logic              r_bus_oe;
    logic [DATA_W-1:0] r_tx_hold;
    logic              r_overrun;
    logic [OVR_W-1:0]  r_ovr_cnt;

    logic              w_tbre_s;
    logic              w_tsre_s;
    logic              w_dr_s;
    logic [DATA_W-1:0] w_tx_head;
    logic              w_tx_empty;
    logic              w_tx_full;
    logic              w_tx_pop;
    logic              w_tx_push;
    logic              w_tx_ready;
    logic              w_rx_empty;
    logic              w_rx_full;
    logic              w_rx_push;
    logic              w_ovr_cond;

    assign w_tbre_s = r_sync2[2];
    assign w_tsre_s = r_sync2[1];
    assign w_dr_s   = r_sync2[0];

    // Mirrors the IDLE branch order: a pending read always beats a write.
    assign w_tx_pop   = (r_state == StIdle) && !w_tx_empty && !(w_dr_s && !w_rx_full);
    assign w_tx_ready = !w_tx_full || w_tx_pop;
    assign w_tx_push  = i_tx_valid && w_tx_ready;
    assign w_rx_push  = (r_state == StRdPulse) && (r_cnt == '0);
    assign w_ovr_cond = (r_state == StIdle) && w_dr_s && w_rx_full;

    assign io_bus_data = r_bus_oe ? r_tx_hold : {DATA_W{1'bz}};
    assign o_rdn       = r_rdn;
    assign o_wrn       = r_wrn;
    assign o_ram_oe    = 1'b1;
    assign o_ram_we    = 1'b1;
    assign o_ram_en    = 1'b1;
    assign o_tx_ready  = w_tx_ready;
    assign o_rx_valid  = !w_rx_empty;
    assign o_status    = {r_state != StIdle, w_tx_full, w_rx_full, r_overrun};

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_tbre, i_tsre, i_data_ready};
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_rdn     <= 1'b1;
            r_wrn     <= 1'b1;
            r_bus_oe  <= 1'b0;
            r_tx_hold <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_dr_s && !w_rx_full) begin
                        r_state <= StRdPulse;
                        r_cnt   <= CNT_W'(PULSE_CYC - 1);
                        r_rdn   <= 1'b0;
                    end else if (!w_tx_empty) begin
                        r_state   <= StWrSetup;
                        r_cnt     <= CNT_W'(SETUP_CYC - 1);
                        r_tx_hold <= w_tx_head;
                        r_bus_oe  <= 1'b1;
                    end
                end
                StWrSetup: begin
                    if (r_cnt == '0) begin
                        r_state <= StWrPulse;
                        r_cnt   <= CNT_W'(PULSE_CYC - 1);
                        r_wrn   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StWrPulse: begin
                    if (r_cnt == '0) begin
                        r_state <= StWrHold;
                        r_cnt   <= '0;
                        r_wrn   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StWrHold: begin
                    r_state  <= StWrWaitTbre;
                    r_bus_oe <= 1'b0;
                end
                StWrWaitTbre: if (w_tbre_s) r_state <= StWrWaitTsre;
                StWrWaitTsre: if (w_tsre_s) r_state <= StIdle;
                StRdPulse: begin
                    if (r_cnt == '0) begin
                        r_state <= StRdRecover;
                        r_cnt   <= CNT_W'(RECOVER_CYC - 1);
                        r_rdn   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StRdRecover: begin
                    if (r_cnt == '0) r_state <= StIdle;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: begin
                    r_state  <= StIdle;
                    r_rdn    <= 1'b1;
                    r_wrn    <= 1'b1;
                    r_bus_oe <= 1'b0;
                end
            endcase
        end
    end

    // Overrun needs the full-RX stall to persist for a whole window of cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (w_ovr_cond) begin
            if (r_ovr_cnt == OVR_W'(OVR_WINDOW - 1)) r_overrun <= 1'b1;
            else                                     r_ovr_cnt <= r_ovr_cnt + 1'b1;
        end else begin
            r_ovr_cnt <= '0;
        end
    end

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_tx_push),
        .i_wr_data (i_tx_data),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_empty   (w_tx_empty),
        .o_full    (w_tx_full),
        .o_count   (o_tx_count)
    );

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_rx_push),
        .i_wr_data (io_bus_data),
        .i_rd_en   (i_rx_ready),
        .o_rd_data (o_rx_data),
        .o_empty   (w_rx_empty),
        .o_full    (w_rx_full),
        .o_count   (o_rx_count)
    );

endmodule

// File: tb/tb_uart_bridge.sv
// Directed bench for uart_bridge: a simple CPLD UART model drives the bus
// during rdn pulses; a pullup makes a released bus read as all ones.
module tb_uart_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tbre = 1'b1;
    logic       tsre = 1'b1;
    logic       dr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] uart_byte = 8'h5A;
    wire  [7:0] bus;
    logic       rdn, wrn, ram_oe, ram_we, ram_en, tx_ready, rx_valid;
    logic [7:0] rx_data;
    logic [4:0] tx_count, rx_count;
    logic [3:0] status;
    int         n_checks = 0;
    int         n_fails = 0;

    always #5 clk = ~clk;

    assign bus = (!rdn) ? uart_byte : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup u_pu (bus[g]);
    end

    uart_bridge u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tbre       (tbre),
        .i_tsre       (tsre),
        .i_data_ready (dr),
        .io_bus_data  (bus),
        .o_rdn        (rdn),
        .o_wrn        (wrn),
        .o_ram_oe     (ram_oe),
        .o_ram_we     (ram_we),
        .o_ram_en     (ram_en),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .i_rx_ready   (rx_ready),
        .o_tx_count   (tx_count),
        .o_rx_count   (rx_count),
        .o_status     (status)
    );

    task automatic wait_wrn(input logic lvl, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (wrn === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h99;
        repeat (3) @(negedge clk);
        n_checks++; if (rdn !== 1'b1) begin n_fails++; $display("FAIL reset_rdn: got %b want 1", rdn); end
        n_checks++; if (wrn !== 1'b1) begin n_fails++; $display("FAIL reset_wrn: got %b want 1", wrn); end
        n_checks++; if (bus !== 8'hFF) begin n_fails++; $display("FAIL reset_bus: got %h want ff", bus); end
        n_checks++; if (tx_count !== 5'd0) begin n_fails++; $display("FAIL reset_txc: got %0d want 0", tx_count); end
        n_checks++; if (rx_count !== 5'd0) begin n_fails++; $display("FAIL reset_rxc: got %0d want 0", rx_count); end
        n_checks++; if (status !== 4'b0000) begin n_fails++; $display("FAIL reset_status: got %b want 0000", status); end
        n_checks++; if ({ram_oe, ram_we, ram_en} !== 3'b111) begin
            n_fails++; $display("FAIL reset_ram: got %b want 111", {ram_oe, ram_we, ram_en});
        end
        tx_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_tx();
        logic [7:0] exp_bus [0:6];
        logic       exp_wrn [0:6];
        exp_bus = '{8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'hFF};
        exp_wrn = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n_checks++; if (tx_count !== 5'd1) begin n_fails++; $display("FAIL tx1_count_push: got %0d want 1", tx_count); end
        for (int k = 0; k < 7; k++) begin
            n_checks++; if (bus !== exp_bus[k]) begin
                n_fails++; $display("FAIL tx1_bus[%0d]: got %h want %h", k, bus, exp_bus[k]);
            end
            n_checks++; if (wrn !== exp_wrn[k]) begin
                n_fails++; $display("FAIL tx1_wrn[%0d]: got %b want %b", k, wrn, exp_wrn[k]);
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        n_checks++; if (tx_count !== 5'd0) begin n_fails++; $display("FAIL tx1_count_end: got %0d want 0", tx_count); end
        n_checks++; if (status !== 4'b0000) begin n_fails++; $display("FAIL tx1_status: got %b want 0000", status); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [0:2];
        bit         ok;
        int         lows;
        bytes = '{8'h11, 8'h22, 8'h33};
        tbre = 1'b0; tsre = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_data = bytes[i]; tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_wrn(1'b0, 40, ok);
            n_checks++; if (!ok) begin n_fails++; $display("FAIL b2b_wrn_timeout[%0d]: got none want pulse", i); end
            n_checks++; if (bus !== bytes[i]) begin
                n_fails++; $display("FAIL b2b_order[%0d]: got %h want %h", i, bus, bytes[i]);
            end
            tbre = 1'b0; tsre = 1'b0;
            wait_wrn(1'b1, 10, ok);
            lows = 0;
            repeat (20) begin if (wrn === 1'b0) lows++; @(negedge clk); end
            n_checks++; if (lows !== 0) begin n_fails++; $display("FAIL b2b_tbre_hold[%0d]: got %0d want 0", i, lows); end
            tbre = 1'b1;
            lows = 0;
            repeat (10) begin if (wrn === 1'b0) lows++; @(negedge clk); end
            n_checks++; if (lows !== 0) begin n_fails++; $display("FAIL b2b_tsre_hold[%0d]: got %0d want 0", i, lows); end
            tsre = 1'b1;
        end
        repeat (10) @(negedge clk);
        n_checks++; if (tx_count !== 5'd0) begin n_fails++; $display("FAIL b2b_count: got %0d want 0", tx_count); end
        n_checks++; if (status !== 4'b0000) begin n_fails++; $display("FAIL b2b_status: got %b want 0000", status); end
    endtask

    task automatic test_priority();
        int         t_rd = -1;
        int         t_wr = -1;
        bit         overlap = 1'b0;
        logic [7:0] wr_bus = 8'h00;
        uart_byte = 8'h5A; dr = 1'b1;
        @(negedge clk);
        tx_data = 8'h77; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (rdn === 1'b0 && t_rd < 0) begin t_rd = t; dr = 1'b0; end
            if (wrn === 1'b0 && t_wr < 0) begin t_wr = t; wr_bus = bus; end
            if (rdn === 1'b0 && wrn === 1'b0) overlap = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (t_rd < 0 || t_wr < 0 || t_rd >= t_wr) begin
            n_fails++; $display("FAIL prio_order: got rd=%0d wr=%0d want 0<=rd<wr", t_rd, t_wr);
        end
        n_checks++; if (overlap !== 1'b0) begin n_fails++; $display("FAIL prio_overlap: got 1 want 0"); end
        n_checks++; if (wr_bus !== 8'h77) begin n_fails++; $display("FAIL prio_txbyte: got %h want 77", wr_bus); end
        n_checks++; if (rx_count !== 5'd1) begin n_fails++; $display("FAIL prio_rxcount: got %0d want 1", rx_count); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fails++; $display("FAIL prio_rxvalid: got %b want 1", rx_valid); end
        n_checks++; if (rx_data !== 8'h5A) begin n_fails++; $display("FAIL prio_rxdata: got %h want 5a", rx_data); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        n_checks++; if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin
            n_fails++; $display("FAIL prio_pop: got count=%0d valid=%b want 0/0", rx_count, rx_valid);
        end
    endtask

    task automatic test_fifo_bounds();
        int  accepted = 0;
        int  cycles = 0;
        int  wait_cyc = 0;
        int  lows = 0;
        bit  rdy;
        tbre = 1'b0; tsre = 1'b0;
        while (accepted < 17 && cycles < 40) begin
            tx_data = 8'h80 + 8'(accepted); tx_valid = 1'b1; rdy = tx_ready;
            @(negedge clk);
            if (rdy) accepted++;
            cycles++;
        end
        tx_valid = 1'b0;
        n_checks++; if (cycles !== 17) begin n_fails++; $display("FAIL txfill_cycles: got %0d want 17", cycles); end
        n_checks++; if (tx_count !== 5'd16) begin n_fails++; $display("FAIL txfill_count: got %0d want 16", tx_count); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fails++; $display("FAIL txfill_ready: got %b want 0", tx_ready); end
        n_checks++; if (status[3:2] !== 2'b11) begin n_fails++; $display("FAIL txfill_status: got %b want 11xx", status); end
        tx_data = 8'hEE; tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        n_checks++; if (tx_count !== 5'd16) begin n_fails++; $display("FAIL txfull_push: got %0d want 16", tx_count); end
        tbre = 1'b1; tsre = 1'b1;
        while (!(tx_count == 5'd0 && status[3] == 1'b0) && wait_cyc < 1000) begin
            @(negedge clk); wait_cyc++;
        end
        n_checks++; if (wait_cyc >= 1000) begin n_fails++; $display("FAIL txdrain_timeout: got count=%0d want 0", tx_count); end

        uart_byte = 8'h3C; dr = 1'b1; wait_cyc = 0;
        while (rx_count != 5'd16 && wait_cyc < 300) begin @(negedge clk); wait_cyc++; end
        n_checks++; if (rx_count !== 5'd16) begin n_fails++; $display("FAIL rxfill_count: got %0d want 16", rx_count); end
        repeat (100) begin if (rdn === 1'b0) lows++; @(negedge clk); end
        n_checks++; if (lows !== 0) begin n_fails++; $display("FAIL rxfull_rdn: got %0d want 0", lows); end
        n_checks++; if (status[1:0] !== 2'b10) begin n_fails++; $display("FAIL rxfull_early: got %b want xx10", status); end
        repeat (170) @(negedge clk);
        n_checks++; if (status[0] !== 1'b1) begin n_fails++; $display("FAIL rx_overrun: got %b want 1", status[0]); end
        n_checks++; if (rx_data !== 8'h3C) begin n_fails++; $display("FAIL rxfull_data: got %h want 3c", rx_data); end
        dr = 1'b0;
        repeat (4) @(negedge clk);
        rx_ready = 1'b1;
        repeat (16) @(negedge clk);
        rx_ready = 1'b0;
        n_checks++; if (rx_count !== 5'd0) begin n_fails++; $display("FAIL rxdrain_count: got %0d want 0", rx_count); end
        n_checks++; if (status[0] !== 1'b1) begin n_fails++; $display("FAIL overrun_sticky: got %b want 1", status[0]); end
    endtask

    task automatic test_reset_midpulse();
        bit ok;
        int lows = 0;
        tbre = 1'b1; tsre = 1'b1;
        tx_data = 8'hC3; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_wrn(1'b0, 10, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL mid_wrn_timeout: got none want pulse"); end
        n_checks++; if (tx_count !== 5'd1) begin n_fails++; $display("FAIL mid_txcount: got %0d want 1", tx_count); end
        @(negedge clk);
        n_checks++; if (wrn !== 1'b0) begin n_fails++; $display("FAIL mid_pulse2: got %b want 0", wrn); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (wrn !== 1'b1 || rdn !== 1'b1) begin
            n_fails++; $display("FAIL mid_strobes: got wrn=%b rdn=%b want 1/1", wrn, rdn);
        end
        n_checks++; if (bus !== 8'hFF) begin n_fails++; $display("FAIL mid_bus: got %h want ff", bus); end
        n_checks++; if (tx_count !== 5'd0 || rx_count !== 5'd0) begin
            n_fails++; $display("FAIL mid_counts: got tx=%0d rx=%0d want 0/0", tx_count, rx_count);
        end
        n_checks++; if (status !== 4'b0000) begin n_fails++; $display("FAIL mid_status: got %b want 0000", status); end
        rst = 1'b1;
        repeat (10) begin if (wrn === 1'b0) lows++; @(negedge clk); end
        n_checks++; if (lows !== 0) begin n_fails++; $display("FAIL mid_after: got %0d want 0", lows); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_priority();
        test_fifo_bounds();
        test_reset_midpulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
